// File: rtl/htu_req_arb.sv
// htu_req_arb: per-channel 2-entry skid FIFOs, a fixed-priority arbiter and a one-entry output
// register. Optional starvation promotion is enabled with `define MPC_HTU_ARB_STARVE_EN.
package htu_req_arb_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  opcode;
    logic [7:0]  tag;
    logic [2:0]  channel_1hot_id;
  } bank_req_t;
endpackage

module htu_req_arb
  import htu_req_arb_pkg::*;
#(
  parameter int NumCh       = 3,
  parameter int ReqWidth    = $bits(bank_req_t),
  parameter int StarveLimit = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NumCh-1:0]               ch_req_valid,
  output logic [NumCh-1:0]               ch_req_ready,
  input  logic [NumCh-1:0][ReqWidth-1:0] ch_req,
  output logic                           out_req_valid,
  input  logic                           out_req_ready,
  output logic [ReqWidth-1:0]            out_req,
  output logic                           arb_idle,
  output logic [NumCh-1:0]               ch_pending
);

  logic [NumCh-1:0][1:0] r_cnt;
  logic [NumCh-1:0]      r_wptr;
  logic [NumCh-1:0]      r_rptr;
  logic [ReqWidth-1:0]   r_mem [NumCh][2];
  logic                  r_out_valid;
  logic [ReqWidth-1:0]   r_out_req;

  logic [NumCh-1:0]    w_pending;
  logic [NumCh-1:0]    w_ready;
  logic [NumCh-1:0]    w_push;
  logic [NumCh-1:0]    w_cand;
  logic [NumCh-1:0]    w_grant;
  logic [NumCh-1:0]    w_pop;
  logic                w_load;
  logic [ReqWidth-1:0] w_head;
  logic [2:0]          w_id;
  bank_req_t           w_next;

  always_comb begin
    for (int i = 0; i < NumCh; i++) begin
      w_pending[i] = (r_cnt[i] != 2'd0);
      w_ready[i]   = (r_cnt[i] != 2'd2);
    end
  end

  assign w_push  = ch_req_valid & w_ready;
  assign w_load  = ~r_out_valid | out_req_ready;
  // Isolating the lowest set bit gives the one-hot, lowest-index-wins grant.
  assign w_grant = w_cand & (~w_cand + NumCh'(1));
  assign w_pop   = w_load ? w_grant : '0;

  // NOTE: every always_comb output gets a default before the loop so no latch is inferred.
  always_comb begin
    w_head = '0;
    w_id   = '0;
    for (int i = 0; i < NumCh; i++) begin
      if (w_grant[i]) w_head = r_mem[i][r_rptr[i]];
      if (i < 3) w_id[i] = w_grant[i];
    end
    w_next                 = bank_req_t'(w_head);
    w_next.channel_1hot_id = w_id;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        if (w_push[i]) r_wptr[i] <= ~r_wptr[i];
        if (w_pop[i])  r_rptr[i] <= ~r_rptr[i];
        case ({w_push[i], w_pop[i]})
          2'b10:   r_cnt[i] <= r_cnt[i] + 2'd1;
          2'b01:   r_cnt[i] <= r_cnt[i] - 2'd1;
          default: r_cnt[i] <= r_cnt[i];
        endcase
      end
    end
  end

  // NOTE: FIFO storage is not reset; the cleared counts already mark every entry invalid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NumCh; i++) begin
      if (w_push[i]) r_mem[i][r_wptr[i]] <= ch_req[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_req   <= '0;
    end else if (w_load) begin
      r_out_valid <= |w_pending;
      if (|w_pending) r_out_req <= w_next;
    end
  end

`ifdef MPC_HTU_ARB_STARVE_EN
  logic [NumCh-1:0][3:0] r_starve;
  logic [NumCh-1:0]      w_promoted;

  always_comb begin
    for (int i = 0; i < NumCh; i++) begin
      w_promoted[i] = w_pending[i] && (r_starve[i] >= 4'(StarveLimit));
    end
  end

  assign w_cand = (|w_promoted) ? w_promoted : w_pending;

  // Counters only move on an effective grant; a stalled output register freezes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else begin
      for (int i = 0; i < NumCh; i++) begin
        if (!w_pending[i] || w_pop[i]) r_starve[i] <= 4'd0;
        else if (|w_pop && r_starve[i] != 4'd15) r_starve[i] <= r_starve[i] + 4'd1;
      end
    end
  end
`else
  assign w_cand = w_pending;
`endif

  assign ch_req_ready  = w_ready;
  assign ch_pending    = w_pending;
  assign out_req_valid = r_out_valid;
  assign out_req       = r_out_req;
  assign arb_idle      = ~|w_pending & ~r_out_valid;

endmodule
